// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: move-immediate op codes
package cpu_pkg;

  typedef enum logic [2:0] {
    MOVE_OP_MOVL  = 3'd0,
    MOVE_OP_MOVLZ = 3'd1,
    MOVE_OP_MOVLS = 3'd2,
    MOVE_OP_MOVH  = 3'd3,
    MOVE_OP_MOVB  = 3'd4
  } move_op_t;

  typedef enum logic {
    MOVE_EMPTY = 1'b0,
    MOVE_FULL  = 1'b1
  } move_state_t;

endpackage

// File: rtl/move_imm_alu.sv
// rtl/move_imm_alu.sv - combinational move-immediate datapath
// Illegal ops and out-of-range MOVB lanes yield result 0 with err set.
module move_imm_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        imm,
  input  logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam int N_LANES = DATA_W / 8;

  logic lane_ok;
  assign lane_ok = (32'(lane) < 32'(N_LANES));

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      MOVE_OP_MOVL:  result = {base[DATA_W-1:8], imm};
      MOVE_OP_MOVLZ: result = {{(DATA_W-8){1'b0}}, imm};
      MOVE_OP_MOVLS: result = {{(DATA_W-8){1'b1}}, imm};
      MOVE_OP_MOVH: begin
        result        = base;
        result[15:8]  = imm;
      end
      MOVE_OP_MOVB: begin
        if (lane_ok) begin
          result = base;
          for (int b = 0; b < N_LANES; b++) begin
            if (lane == LANE_W'(b)) result[b*8 +: 8] = imm;
          end
        end else begin
          err = 1'b1;
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/move_imm_unit.sv
// rtl/move_imm_unit.sv - move-immediate unit with one-entry output register
// Optional forwarding of the held result is compiled in with MOVE_IMM_FWD_EN.
module move_imm_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  localparam int DST_W  = $clog2(REG_N),
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DST_W-1:0]  dst,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        imm,
  input  logic [DATA_W-1:0] dst_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DST_W-1:0]  out_dst,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err
);

  move_state_t state, state_n;
  logic              accept;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;

  assign out_valid = (state == MOVE_FULL);
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

`ifdef MOVE_IMM_FWD_EN
  // Merge onto the still-held result so back-to-back writes to one register chain.
  assign base = (out_valid && (out_dst == dst) && !out_err) ? out_result : dst_val;
`else
  assign base = dst_val;
`endif

  move_imm_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .lane   (lane),
    .imm    (imm),
    .base   (base),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    state_n = state;
    case (state)
      MOVE_EMPTY: if (accept) state_n = MOVE_FULL;
      MOVE_FULL:  if (out_ready && !accept) state_n = MOVE_EMPTY;
      default:    state_n = MOVE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MOVE_EMPTY;
      out_dst    <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        out_dst    <= dst;
        out_result <= alu_result;
        out_err    <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_move_imm_unit.sv
// tb/tb_move_imm_unit.sv - directed self-checking bench for move_imm_unit (16- and 32-bit instances)
module tb_move_imm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [2:0]  dst;
  logic [7:0]  imm;
  logic [1:0]  lane32;
  logic        lane16;
  logic [31:0] dst_val32;
  logic [15:0] dst_val16;

  logic        in_ready32, out_valid32, out_err32;
  logic [2:0]  out_dst32;
  logic [31:0] out_result32;
  logic        in_ready16, out_valid16, out_err16;
  logic [2:0]  out_dst16;
  logic [15:0] out_result16;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  move_imm_unit #(.DATA_W(32), .REG_N(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .op(op), .dst(dst), .lane(lane32), .imm(imm), .dst_val(dst_val32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_dst(out_dst32),
    .out_result(out_result32), .out_err(out_err32)
  );

  move_imm_unit #(.DATA_W(16), .REG_N(8)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .op(op), .dst(dst), .lane(lane16), .imm(imm), .dst_val(dst_val16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_dst(out_dst16),
    .out_result(out_result16), .out_err(out_err16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain any held result, then present one request for exactly one cycle.
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [1:0] ln,
                       input logic [7:0] im, input logic [15:0] v16, input logic [31:0] v32);
    in_valid = 1'b0;
    step();
    op = o; dst = d; lane32 = ln; lane16 = ln[0]; imm = im;
    dst_val16 = v16; dst_val32 = v32;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; dst = 3'd0; imm = 8'h00; lane32 = 2'd0; lane16 = 1'b0;
    dst_val32 = '0; dst_val16 = '0;
    step();
    step();
    check("rst_in_ready", in_ready32, 0);
    check("rst_out_valid", out_valid32, 0);
    check("rst_out_result", out_result32, 0);
    check("rst_out_err", out_err32, 0);
    check("rst_out_dst", out_dst32, 0);

    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready32, 1);

    // MOVL
    issue(3'd0, 3'd1, 2'd0, 8'h12, 16'hABCD, 32'h11223344);
    check("movl16_valid", out_valid16, 1);
    check("movl16_result", out_result16, 16'hAB12);
    check("movl16_dst", out_dst16, 3'd1);
    check("movl32_result", out_result32, 32'h11223312);
    check("movl32_err", out_err32, 0);
    step();
    check("pop_clears_valid", out_valid32, 0);

    // MOVLS / MOVLZ / MOVH
    issue(3'd2, 3'd5, 2'd0, 8'h80, 16'h1234, 32'h12345678);
    check("movls32_result", out_result32, 32'hFFFFFF80);
    check("movls16_result", out_result16, 16'hFF80);
    issue(3'd1, 3'd6, 2'd0, 8'h34, 16'hFFFF, 32'hFFFFFFFF);
    check("movlz32_result", out_result32, 32'h00000034);
    issue(3'd3, 3'd7, 2'd0, 8'hEE, 16'h3344, 32'h11223344);
    check("movh32_result", out_result32, 32'h1122EE44);
    check("movh16_result", out_result16, 16'hEE44);

    // MOVB
    issue(3'd4, 3'd0, 2'd3, 8'h5A, 16'h0000, 32'h00000000);
    check("movb32_lane3", out_result32, 32'h5A000000);
    check("movb16_lane1", out_result16, 16'h5A00);
    check("movb32_err", out_err32, 0);
    issue(3'd4, 3'd1, 2'd0, 8'h77, 16'hAAAA, 32'hAAAAAAAA);
    check("movb32_lane0", out_result32, 32'hAAAAAA77);
    check("movb16_lane0", out_result16, 16'hAA77);

    // Illegal ops
    issue(3'd6, 3'd2, 2'd0, 8'hFF, 16'hFFFF, 32'hFFFFFFFF);
    check("op6_result", out_result32, 0);
    check("op6_err", out_err32, 1);
    check("op6_valid", out_valid32, 1);
    issue(3'd5, 3'd2, 2'd0, 8'hFF, 16'hFFFF, 32'hFFFFFFFF);
    check("op5_err16", out_err16, 1);
    issue(3'd7, 3'd2, 2'd0, 8'hFF, 16'hFFFF, 32'hFFFFFFFF);
    check("op7_result16", out_result16, 0);

    // Stall, then simultaneous pop and accept
    issue(3'd0, 3'd3, 2'd0, 8'h11, 16'h0000, 32'h00000000);
    out_ready = 1'b0;
    op = 3'd1; dst = 3'd4; imm = 8'h22; dst_val32 = 32'hDEADBEEF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", in_ready32, 0);
      check("stall_valid", out_valid32, 1);
      check("stall_result", out_result32, 32'h00000011);
      check("stall_dst", out_dst32, 3'd3);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready32, 1);
    step();
    in_valid = 1'b0;
    check("popacc_valid", out_valid32, 1);
    check("popacc_result", out_result32, 32'h00000022);
    check("popacc_dst", out_dst32, 3'd4);

    // Reset while stalled discards the held result
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_valid", out_valid32, 0);
    check("midrst_in_ready", in_ready32, 0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", in_ready32, 1);
    step();
    check("midrst_nothing_emitted", out_valid32, 0);
    out_ready = 1'b1;

    // Back-to-back merge into r2 with stale dst_val
    op = 3'd1; dst = 3'd2; imm = 8'h34; dst_val32 = '0; dst_val16 = '0;
    in_valid = 1'b1;
    step();
    check("merge_first", out_result32, 32'h00000034);
    op = 3'd3; imm = 8'h12;
    step();
    in_valid = 1'b0;
`ifdef MOVE_IMM_FWD_EN
    check("merge_fwd32", out_result32, 32'h00001234);
    check("merge_fwd16", out_result16, 16'h1234);
`else
    check("merge_nofwd32", out_result32, 32'h00001200);
    check("merge_nofwd16", out_result16, 16'h1200);
`endif
    step();
    check("final_drain", out_valid32, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/move_imm_unit.md
MOVE_IMM_UNIT -- requirements
Module: move_imm_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register width; a multiple of 8, legal range 16..64.
REQ-002 SHALL have parameter REG_N, default 8: register count; DST_W = $clog2(REG_N); LANE_W = $clog2(DATA_W/8).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: a request is present.
REQ-006 SHALL have port in_ready, output, 1: the unit accepts a request this cycle.
REQ-007 SHALL have port op, input, 3: operation code. 0 MOVL, 1 MOVLZ, 2 MOVLS, 3 MOVH, 4 MOVB; 5..7 are illegal.
REQ-008 SHALL have port dst, input, DST_W: destination register index.
REQ-009 SHALL have port lane, input, LANE_W: byte lane for MOVB, ignored for all other ops.
REQ-010 SHALL have port imm, input, 8: immediate byte.
REQ-011 SHALL have port dst_val, input, DATA_W: current register-file value of dst.
REQ-012 SHALL have port out_valid, output, 1: a result is held.
REQ-013 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-014 SHALL have ports out_dst (output, DST_W) and out_result (output, DATA_W): the held write-back.
REQ-015 SHALL have port out_err, output, 1: the held result came from an illegal op or lane.

Function
REQ-016 SHALL accept a request when in_valid && in_ready, where in_ready = !out_valid || out_ready.
REQ-017 SHALL register the result one cycle after acceptance: out_valid=1, out_dst=dst.
REQ-018 SHALL compute MOVL as base with bits [7:0] replaced by imm.
REQ-019 SHALL compute MOVLZ as {zeros, imm}.
REQ-020 SHALL compute MOVLS as {ones, imm}, with all bits above bit 7 set to 1.
REQ-021 SHALL compute MOVH as base with bits [15:8] replaced by imm; bits above bit 15 are preserved.
REQ-022 SHALL compute MOVB as base with byte lane `lane` replaced by imm.
REQ-023 SHALL treat an illegal op, or a MOVB lane >= DATA_W/8, as follows: out_result=0, out_err=1, and the transfer still occurs.
REQ-024 SHALL hold out_* stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid when out_ready=1 and no new request is accepted.
REQ-026 SHALL support full throughput on simultaneous output pop and input accept: one result per cycle, with no bubble.
REQ-027 SHALL use two states for the output FSM: EMPTY goes to FULL on accept; FULL goes to EMPTY on a pop without accept; FULL stays FULL on pop with accept, or on a stall.
REQ-028 SHALL use base = dst_val, unless REQ-034 applies.

Reset
REQ-029 SHALL, while rst=1, drive out_valid=0, out_dst=0, out_result=0, out_err=0, and the FSM to EMPTY.
REQ-030 SHALL hold in_ready=0 while rst=1.
REQ-031 SHALL discard any held result when rst is asserted mid-stall; nothing is emitted after reset.
REQ-032 SHALL give in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL compile the forwarding path only when macro MOVE_IMM_FWD_EN is defined.
REQ-034 SHALL, with MOVE_IMM_FWD_EN, set base = out_result when out_valid && out_dst==dst && !out_err at accept, covering back-to-back merges to the same register.
REQ-035 SHALL, without MOVE_IMM_FWD_EN, always use base = dst_val; the producer then owns hazard avoidance.

Structure
REQ-036 SHALL place the op encoding enum (move_op_t) and the MOVE_OP_* constants in the shared package cpu_pkg.
REQ-037 SHALL implement a combinational sub-module move_imm_alu (op, lane, imm, base -> result, err), with the pipeline register in move_imm_unit.

Verification
REQ-038 SHALL cover: DATA_W=16, MOVL, dst_val=0xABCD, imm=0x12 -> next cycle out_result=0xAB12, out_valid=1.
REQ-039 SHALL cover: DATA_W=32, MOVLS imm=0x80 -> 0xFFFFFF80; MOVH dst_val=0x11223344, imm=0xEE -> 0x1122EE44.
REQ-040 SHALL cover: DATA_W=32, MOVB lane=3, imm=0x5A, dst_val=0 -> 0x5A000000; op=6 -> out_result=0, out_err=1.
REQ-041 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; then out_ready=1 -> pop and accept in the same cycle.
REQ-042 SHALL cover: with MOVE_IMM_FWD_EN, MOVLZ r2 imm=0x34 then MOVH r2 imm=0x12 back-to-back with stale dst_val=0 -> 0x1234; without the macro -> 0x1200.
REQ-043 SHALL cover: rst pulsed while out_valid=1 and stalled -> out_valid=0 next cycle and in_ready=1 after release.
